// File: rtl/obstacle_scroller.sv
// Scrolling pipe/coin X-position engine: a ring of NUM_OBS obstacles, current-obstacle tracking and pass counting.
// Optional macro SCROLLER_PAUSE_EN adds a PAUSE state driven by the pause input.
module obstacle_scroller #(
  parameter int NUM_OBS  = 5,
  parameter int XW       = 10,
  parameter int OBJ_W    = 160,
  parameter int INTERVAL = 160,
  parameter int COIN_OFF = 70,
  parameter int COIN_W   = 20,
  parameter int BIRD_X   = 230,
  parameter int CUR_INIT = 1,
  parameter int SPEED_W  = 3,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  ack,
  input  logic                  pause,
  input  logic                  tick,
  input  logic [SPEED_W-1:0]    speed,
  output logic [NUM_OBS*XW-1:0] pipe_l_flat,
  output logic [NUM_OBS*XW-1:0] pipe_r_flat,
  output logic [NUM_OBS*XW-1:0] coin_l_flat,
  output logic [NUM_OBS*XW-1:0] coin_r_flat,
  output logic [2:0]            cur_idx,
  output logic                  passed,
  output logic [CNT_W-1:0]      pass_count,
  output logic                  q_init,
  output logic                  q_run,
  output logic                  q_stop,
  output logic                  q_pause
);

  localparam logic [3:0]    ST_INIT  = 4'b0001;
  localparam logic [3:0]    ST_RUN   = 4'b0010;
  localparam logic [3:0]    ST_STOP  = 4'b0100;
  localparam logic [3:0]    ST_PAUSE = 4'b1000;
  localparam logic [XW-1:0] RING     = XW'(NUM_OBS * INTERVAL);
  localparam logic [XW-1:0] BIRD     = XW'(BIRD_X);
  localparam logic [2:0]    CUR0     = 3'(CUR_INIT);
  localparam logic [2:0]    LAST     = 3'(NUM_OBS - 1);

  function automatic logic [XW-1:0] sat0(input int v);
    if (v < 0) sat0 = {XW{1'b0}};
    else       sat0 = XW'(v);
  endfunction

  logic [3:0]       state_q, state_d;
  logic [XW-1:0]    r_q [NUM_OBS];
  logic [XW-1:0]    r_d [NUM_OBS];
  logic [2:0]       cur_q, cur_d;
  logic             passed_q, passed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             move_s;
  logic [XW-1:0]    spd_s;
  logic [XW-1:0]    cur_new_s;
  logic [XW-1:0]    slot_r_s [NUM_OBS];

  assign spd_s = XW'(speed);

  // FSM next state; stop outranks pause, which outranks tick
  always_comb begin
    state_d = state_q;
    move_s  = 1'b0;
    case (state_q)
      ST_INIT: if (start) state_d = ST_RUN; else state_d = ST_INIT;
      ST_RUN: begin
        if (stop) state_d = ST_STOP;
`ifdef SCROLLER_PAUSE_EN
        else if (pause) state_d = ST_PAUSE;
`endif
        else begin
          state_d = ST_RUN;
          move_s  = tick && (speed != {SPEED_W{1'b0}});
        end
      end
      ST_STOP: if (ack) state_d = ST_INIT; else state_d = ST_STOP;
`ifdef SCROLLER_PAUSE_EN
      ST_PAUSE: begin
        if (stop)        state_d = ST_STOP;
        else if (!pause) state_d = ST_RUN;
        else             state_d = ST_PAUSE;
      end
`endif
      default: state_d = ST_INIT;
    endcase
  end

  // Position ring, current obstacle and pass counter
  always_comb begin
    r_d       = r_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    passed_d  = 1'b0;
    cur_new_s = {XW{1'b0}};
    if (state_q == ST_INIT) begin
      for (int i = 0; i < NUM_OBS; i++) r_d[i] = XW'(OBJ_W + i * INTERVAL);
      cur_d = CUR0;
      cnt_d = {CNT_W{1'b0}};
    end else if (move_s) begin
      // Wrapping by a whole ring length keeps spacing exact and avoids underflow
      for (int i = 0; i < NUM_OBS; i++) begin
        if (r_q[i] <= spd_s) r_d[i] = r_q[i] - spd_s + RING;
        else                 r_d[i] = r_q[i] - spd_s;
      end
      for (int i = 0; i < NUM_OBS; i++)
        cur_new_s = (cur_q == 3'(i)) ? r_d[i] : cur_new_s;
      if (cur_new_s < BIRD) begin
        cur_d    = (cur_q == LAST) ? 3'd0 : cur_q + 3'd1;
        passed_d = 1'b1;
        cnt_d    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
      end else begin
        passed_d = 1'b0;
      end
    end else begin
      r_d = r_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_INIT;
      for (int i = 0; i < NUM_OBS; i++) r_q[i] <= XW'(OBJ_W + i * INTERVAL);
      cur_q    <= CUR0;
      passed_q <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      cur_q    <= cur_d;
      passed_q <= passed_d;
      cnt_q    <= cnt_d;
    end
  end

  // Rotate the ring so slot k shows obstacle (cur+k) mod NUM_OBS
  always_comb begin
    for (int k = 0; k < NUM_OBS; k++) begin
      slot_r_s[k] = {XW{1'b0}};
      for (int i = 0; i < NUM_OBS; i++)
        slot_r_s[k] = (((int'(cur_q) + k) % NUM_OBS) == i) ? r_q[i] : slot_r_s[k];
    end
  end

  for (genvar k = 0; k < NUM_OBS; k++) begin : g_slot
    assign pipe_r_flat[k*XW +: XW] = slot_r_s[k];
    assign pipe_l_flat[k*XW +: XW] = sat0(int'(slot_r_s[k]) - OBJ_W);
    assign coin_r_flat[k*XW +: XW] = sat0(int'(slot_r_s[k]) - OBJ_W + COIN_OFF + COIN_W);
    assign coin_l_flat[k*XW +: XW] = sat0(int'(coin_r_flat[k*XW +: XW]) - COIN_W);
  end

  assign cur_idx    = cur_q;
  assign passed     = passed_q;
  assign pass_count = cnt_q;
  assign q_init     = state_q[0];
  assign q_run      = state_q[1];
  assign q_stop     = state_q[2];
`ifdef SCROLLER_PAUSE_EN
  assign q_pause    = state_q[3];
`else
  assign q_pause    = 1'b0;
  logic unused_pause_s;
  assign unused_pause_s = pause;
`endif

endmodule

// File: tb/tb_obstacle_scroller.sv
// Directed bench for obstacle_scroller; a second instance with CNT_W=2 shares stimulus to check saturation.
module tb_obstacle_scroller;
  logic clk = 1'b0;
  logic reset, start, stop, ack, pause, tick;
  logic [2:0] speed;
  logic [49:0] pl, pr, cl, cr, pl2, pr2, cl2, cr2;
  logic [2:0] cur, cur2;
  logic passed, passed2;
  logic [7:0] cnt;
  logic [1:0] cnt2;
  logic qi, qr, qs, qp, qi2, qr2, qs2, qp2;
  int checks = 0;
  int errors = 0;
  int pulses = 0;

  obstacle_scroller dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .ack(ack), .pause(pause),
    .tick(tick), .speed(speed), .pipe_l_flat(pl), .pipe_r_flat(pr), .coin_l_flat(cl),
    .coin_r_flat(cr), .cur_idx(cur), .passed(passed), .pass_count(cnt),
    .q_init(qi), .q_run(qr), .q_stop(qs), .q_pause(qp));

  obstacle_scroller #(.CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .ack(ack), .pause(pause),
    .tick(tick), .speed(speed), .pipe_l_flat(pl2), .pipe_r_flat(pr2), .coin_l_flat(cl2),
    .coin_r_flat(cr2), .cur_idx(cur2), .passed(passed2), .pass_count(cnt2),
    .q_init(qi2), .q_run(qr2), .q_stop(qs2), .q_pause(qp2));

  always #5 clk = ~clk;

  function automatic logic [31:0] slot(input logic [49:0] f, input int k);
    slot = 32'(f[k*10 +: 10]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      pulses += int'(passed);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; ack = 1'b0; pause = 1'b0; tick = 1'b0;
    speed = 3'd1;
    idle(2);
    reset = 1'b0;
    idle(1);
    chk("rst_q_init", 32'(qi), 32'd1);
    chk("rst_q_run", 32'(qr), 32'd0);
    chk("rst_q_stop", 32'(qs), 32'd0);
    chk("rst_q_pause", 32'(qp), 32'd0);
    chk("rst_cur", 32'(cur), 32'd1);
    chk("rst_passed", 32'(passed), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_slot0_r", slot(pr, 0), 32'd320);
    chk("rst_slot4_r", slot(pr, 4), 32'd160);
    chk("rst_slot4_l", slot(pl, 4), 32'd0);

    do_tick(1);
    chk("init_ignores_tick", slot(pr, 0), 32'd320);
    pulse_start();
    chk("start_q_run", 32'(qr), 32'd1);

    // one tick at speed 1
    do_tick(1);
    chk("t1_pipe_r", slot(pr, 0), 32'd319);
    chk("t1_pipe_l", slot(pl, 0), 32'd159);
    chk("t1_coin_l", slot(cl, 0), 32'd229);
    chk("t1_coin_r", slot(cr, 0), 32'd249);
    chk("t1_cur", 32'(cur), 32'd1);
    speed = 3'd0;
    do_tick(1);
    chk("speed0_hold", slot(pr, 0), 32'd319);

    // advance when R[1] reaches 229
    speed = 3'd1;
    pulses = 0;
    do_tick(89);
    chk("t2_at_230_cur", 32'(cur), 32'd1);
    do_tick(1);
    chk("t2_cur", 32'(cur), 32'd2);
    chk("t2_passed_hi", 32'(passed), 32'd1);
    idle(1);
    chk("t2_passed_lo", 32'(passed), 32'd0);
    chk("t2_pulses", 32'(pulses), 32'd1);
    chk("t2_cnt", 32'(cnt), 32'd1);
    chk("t2_cnt_c2", 32'(cnt2), 32'd1);
    chk("t2_slot0_r", slot(pr, 0), 32'd389);

    // bring R[0] to 3, then wrap with speed 7
    speed = 3'd7;
    do_tick(9);
    speed = 3'd1;
    do_tick(3);
    chk("t3_pre_r0", slot(pr, 3), 32'd3);
    chk("t3_pre_l0", slot(pl, 3), 32'd0);
    chk("t3_pre_cr0", slot(cr, 3), 32'd0);
    chk("t3_pre_cl0", slot(cl, 3), 32'd0);
    speed = 3'd7;
    do_tick(1);
    chk("t3_slot3_r", slot(pr, 3), 32'd796);
    chk("t3_slot3_l", slot(pl, 3), 32'd636);
    chk("t3_slot3_cr", slot(cr, 3), 32'd726);
    chk("t3_slot3_cl", slot(cl, 3), 32'd706);
    chk("t3_slot0_r", slot(pr, 0), 32'd316);
    chk("t3_slot1_r", slot(pr, 1), 32'd476);
    chk("t3_slot2_r", slot(pr, 2), 32'd636);
    chk("t3_slot4_r", slot(pr, 4), 32'd156);
    chk("t3_slot4_l", slot(pl, 4), 32'd0);
    chk("t3_slot4_cr", slot(cr, 4), 32'd86);
    chk("t3_slot4_cl", slot(cl, 4), 32'd66);
    chk("t3_cur", 32'(cur), 32'd2);

    // stop and tick together
    stop = 1'b1; tick = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0; tick = 1'b0;
    chk("t4_q_stop", 32'(qs), 32'd1);
    chk("t4_q_run", 32'(qr), 32'd0);
    chk("t4_hold", slot(pr, 0), 32'd316);
    do_tick(3);
    chk("t4_stop_hold", slot(pr, 0), 32'd316);
    chk("t4_stop_cnt", 32'(cnt), 32'd1);
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
    chk("t4_q_init", 32'(qi), 32'd1);
    idle(1);
    chk("t4_reload_r", slot(pr, 0), 32'd320);
    chk("t4_reload_cur", 32'(cur), 32'd1);
    chk("t4_reload_cnt", 32'(cnt), 32'd0);

    // five advances, 770 pixels at speed 7
    pulse_start();
    speed = 3'd7;
    pulses = 0;
    do_tick(110);
    chk("t5_pulses", 32'(pulses), 32'd5);
    chk("t5_cnt", 32'(cnt), 32'd5);
    chk("t5_cnt_sat", 32'(cnt2), 32'd3);
    chk("t5_cur", 32'(cur), 32'd1);
    chk("t5_slot0_r", slot(pr, 0), 32'd350);
    chk("t5_slot1_r", slot(pr, 1), 32'd510);

    // pause for 10 ticks
    speed = 3'd1;
    pause = 1'b1;
    idle(1);
    do_tick(10);
`ifdef SCROLLER_PAUSE_EN
    chk("t6_q_pause", 32'(qp), 32'd1);
    chk("t6_paused_r", slot(pr, 0), 32'd350);
`else
    chk("t6_q_pause", 32'(qp), 32'd0);
    chk("t6_paused_r", slot(pr, 0), 32'd340);
`endif
    pause = 1'b0;
    idle(1);
    do_tick(1);
    chk("t6_resume_q_run", 32'(qr), 32'd1);
`ifdef SCROLLER_PAUSE_EN
    chk("t6_resume_r", slot(pr, 0), 32'd349);
`else
    chk("t6_resume_r", slot(pr, 0), 32'd339);
`endif

    // reset wins mid-RUN
    reset = 1'b1; tick = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; tick = 1'b0;
    chk("rst_run_q_init", 32'(qi), 32'd1);
    chk("rst_run_q_run", 32'(qr), 32'd0);
    chk("rst_run_cur", 32'(cur), 32'd1);
    chk("rst_run_cnt", 32'(cnt), 32'd0);
    chk("rst_run_r", slot(pr, 0), 32'd320);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
